// File: rtl/irq_pkg.sv
// Shared constants and helpers for the nested interrupt controller:
// default vector layout, handler vector arithmetic and stack depth width.
package irq_pkg;

  localparam logic [31:0] VEC_BASE_DEF   = 32'h38;
  localparam logic [31:0] VEC_STRIDE_DEF = 32'h38;

  // Width of a counter able to hold 0..n inclusive.
  function automatic int depth_w(input int n);
    return $clog2(n + 1);
  endfunction

  // Handler address of line idx; callers truncate to their PC width.
  function automatic logic [63:0] vec(input logic [63:0] base,
                                      input logic [63:0] stride,
                                      input int idx);
    return base + stride * 64'(idx);
  endfunction

endpackage

// File: rtl/irq_nest_ctrl_ret_stack.sv
// Return-address LIFO for nested handlers. The top entry is visible
// combinationally so a pop can use it in the same cycle.
module ret_stack
  import irq_pkg::*;
#(
  parameter int DEPTH = 3,
  parameter int W     = 32,
  parameter int CW    = depth_w(DEPTH)
) (
  input  logic          clk,
  input  logic          clr,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  din,
  output logic [W-1:0]  top,
  output logic [CW-1:0] count
);

  logic [W-1:0]  mem_q [DEPTH];
  logic [W-1:0]  mem_d [DEPTH];
  logic [CW-1:0] count_q, count_d;

  always_comb begin
    mem_d   = mem_q;
    count_d = count_q;
    top     = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (CW'(i + 1) == count_q) top = mem_q[i];
      if (push && (CW'(i) == count_q)) mem_d[i] = din;
    end
    if (push && !pop) count_d = count_q + CW'(1);
    else if (pop && !push && (count_q != '0)) count_d = count_q - CW'(1);
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      count_q <= count_d;
      mem_q   <= mem_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/irq_nest_ctrl.sv
// Nested interrupt controller beside the PC mux: edge capture, priority
// preemption, return-address stacking and registered redirect pulses.
module irq_nest_ctrl
  import irq_pkg::*;
#(
  parameter int              NUM_IRQ    = 3,
  parameter int              ADDR_W     = 32,
  parameter logic [ADDR_W-1:0] VEC_BASE   = ADDR_W'(VEC_BASE_DEF),
  parameter logic [ADDR_W-1:0] VEC_STRIDE = ADDR_W'(VEC_STRIDE_DEF)
) (
  input  logic                           clk,
  input  logic                           clr,
  input  logic                           enable,
  input  logic [NUM_IRQ-1:0]             irq_req,
  input  logic [NUM_IRQ-1:0]             irq_mask,
  input  logic                           gie,
  input  logic                           eret,
  input  logic [ADDR_W-1:0]              pc_ret,
  output logic                           redir_valid,
  output logic [ADDR_W-1:0]              redir_pc,
  output logic [NUM_IRQ-1:0]             irq_ack,
  output logic [NUM_IRQ-1:0]             active,
  output logic [NUM_IRQ-1:0]             pending,
  output logic [$clog2(NUM_IRQ+1)-1:0]   depth,
  output logic                           err_underflow
);

  localparam int DW = depth_w(NUM_IRQ);

  logic [NUM_IRQ-1:0] req_s1_q, req_s1_d, req_s2_q, req_s2_d;
  logic [NUM_IRQ-1:0] pending_q, pending_d, active_q, active_d;
  logic [NUM_IRQ-1:0] irq_ack_q, irq_ack_d;
  logic               redir_valid_q, redir_valid_d, err_q, err_d;
  logic [ADDR_W-1:0]  redir_pc_q, redir_pc_d;

  logic [NUM_IRQ-1:0] elig, cur_oh, cand_oh;
  int                 cand_idx;
  logic               dec_en, do_pop, do_uf, do_take;
  logic [DW-1:0]      stk_count;
  logic [ADDR_W-1:0]  stk_top;

  // One-hot levels compare numerically, so "candidate above current"
  // is a plain magnitude test; no active level gives cur_oh = 0.
  always_comb begin
    elig     = pending_q & ~irq_mask & {NUM_IRQ{gie}};
    cur_oh   = '0;
    cand_oh  = '0;
    cand_idx = 0;
    for (int i = 0; i < NUM_IRQ; i++) begin
      if (active_q[i]) cur_oh = NUM_IRQ'(1) << i;
      if (elig[i]) begin
        cand_oh  = NUM_IRQ'(1) << i;
        cand_idx = i;
      end
    end
  end

  always_comb begin
    dec_en  = enable & ~redir_valid_q;
    do_pop  = dec_en & eret & (stk_count != '0);
    do_uf   = dec_en & eret & (stk_count == '0);
    do_take = dec_en & ~eret & (cand_oh > cur_oh);

    req_s1_d      = irq_req;
    req_s2_d      = req_s1_q;
    pending_d     = pending_q;
    active_d      = active_q;
    irq_ack_d     = '0;
    redir_valid_d = do_pop | do_take;
    redir_pc_d    = redir_pc_q;
    err_d         = err_q | do_uf;

    if (do_pop) begin
      active_d   = active_q & ~cur_oh;
      redir_pc_d = stk_top;
    end else if (do_take) begin
      active_d   = active_q | cand_oh;
      pending_d  = pending_q & ~cand_oh;
      irq_ack_d  = cand_oh;
      redir_pc_d = ADDR_W'(vec(64'(VEC_BASE), 64'(VEC_STRIDE), cand_idx));
    end
    // A fresh edge beats a same-cycle take.
    pending_d = pending_d | (req_s1_q & ~req_s2_q);
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      req_s1_q      <= '0;
      req_s2_q      <= '0;
      pending_q     <= '0;
      active_q      <= '0;
      irq_ack_q     <= '0;
      redir_valid_q <= 1'b0;
      redir_pc_q    <= '0;
      err_q         <= 1'b0;
    end else begin
      req_s1_q      <= req_s1_d;
      req_s2_q      <= req_s2_d;
      pending_q     <= pending_d;
      active_q      <= active_d;
      irq_ack_q     <= irq_ack_d;
      redir_valid_q <= redir_valid_d;
      redir_pc_q    <= redir_pc_d;
      err_q         <= err_d;
    end
  end

  ret_stack #(.DEPTH(NUM_IRQ), .W(ADDR_W), .CW(DW)) u_stack (
    .clk   (clk),
    .clr   (clr),
    .push  (do_take),
    .pop   (do_pop),
    .din   (pc_ret),
    .top   (stk_top),
    .count (stk_count)
  );

  assign redir_valid   = redir_valid_q;
  assign redir_pc      = redir_pc_q;
  assign irq_ack       = irq_ack_q;
  assign active        = active_q;
  assign pending       = pending_q;
  assign depth         = stk_count;
  assign err_underflow = err_q;

endmodule
